// File: rtl/fifo_pkg.sv
// Shared constants and the width helper used by the FIFO read-side blocks.
package fifo_pkg;

   localparam int FIFO_RD_LAT_MAX = 2;
   localparam int FIFO_PKT_CNT_W  = 16;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Small circular buffer holding words returned by the FIFO RAM until the sink
// takes them; head entry is presented combinationally.
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int SKID_DEPTH = 2,
   parameter int DATA_WIDTH = 8
) (
   input  logic                            clk,
   input  logic                            sclr,
   input  logic                            push,
   input  logic [DATA_WIDTH-1:0]           push_data,
   input  logic                            pop,
   output logic [DATA_WIDTH-1:0]           head_data,
   output logic [clog2(SKID_DEPTH+1)-1:0]  count
);

   localparam int IW = (clog2(SKID_DEPTH) < 1) ? 1 : clog2(SKID_DEPTH);
   localparam int CW = clog2(SKID_DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
   logic [IW-1:0]         wr_idx_q, wr_idx_d;
   logic [IW-1:0]         rd_idx_q, rd_idx_d;
   logic [CW-1:0]         count_q, count_d;

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
      return (i == IW'(SKID_DEPTH - 1)) ? '0 : i + 1'b1;
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_idx_q] = push_data;
         wr_idx_d        = wrap_inc(wr_idx_q);
      end
      if (pop) rd_idx_d = wrap_inc(rd_idx_q);
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         count_q  <= '0;
      end else begin
         // upstream credit accounting must make both of these impossible
         assert (!(push && !pop && count_q == CW'(SKID_DEPTH)));
         assert (!(pop && count_q == '0));
         mem_q    <= mem_d;
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
         count_q  <= count_d;
      end
   end

   assign head_data = mem_q[rd_idx_q];
   assign count     = count_q;

endmodule

// File: rtl/fifo_read_streamer.sv
// Read-side drain engine for dual_clock_fifo: credit-controlled rdreq, read latency
// absorption and a bubble-free valid/ready output. FIFO_STREAM_LAST_EN adds m_last framing.
module fifo_read_streamer
   import fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int RD_LATENCY = 1,
   parameter  int PKT_LEN    = 16,
   localparam int SKID_DEPTH = RD_LATENCY + 1,
   localparam int OCC_W      = clog2(SKID_DEPTH + 1)
) (
   input  logic                  rd_clk,
   input  logic                  sclr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  empty,
   output logic                  rdreq,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
`ifdef FIFO_STREAM_LAST_EN
   output logic                  m_last,
`endif
   output logic [OCC_W-1:0]      occupancy
);

   localparam int CRW = clog2(2 * SKID_DEPTH + 2);

   if (RD_LATENCY < 1 || RD_LATENCY > FIFO_RD_LAT_MAX || PKT_LEN < 1 || PKT_LEN > 65535)
   begin : g_bad_cfg
      $error("fifo_read_streamer: illegal RD_LATENCY or PKT_LEN");
   end

   // pipe_q[k] is set when a read was issued k+1 cycles ago
   logic [RD_LATENCY-1:0] pipe_q, pipe_d;
   logic                  pop;
   logic [CRW-1:0]        credit_used;

   assign pop = m_valid && m_ready;

   // A slot is reserved at issue time, so a pop in this cycle frees one for reuse.
   always_comb begin
      credit_used = CRW'(occupancy) + CRW'($countones(pipe_q));
      rdreq       = !empty && !sclr && (credit_used < CRW'(SKID_DEPTH) + CRW'(pop));
      pipe_d      = RD_LATENCY'({pipe_q, rdreq});
   end

   fifo_skid_buf #(
      .SKID_DEPTH (SKID_DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk       (rd_clk),
      .sclr      (sclr),
      .push      (pipe_q[RD_LATENCY-1]),
      .push_data (rd_data),
      .pop       (pop),
      .head_data (m_data),
      .count     (occupancy)
   );

   assign m_valid = (occupancy != '0);

`ifdef FIFO_STREAM_LAST_EN
   logic [FIFO_PKT_CNT_W-1:0] beat_q, beat_d;
   logic                      beat_last;

   assign beat_last = (beat_q == FIFO_PKT_CNT_W'(PKT_LEN - 1));
   assign m_last    = m_valid && beat_last;

   always_comb begin
      beat_d = beat_q;
      if (pop) beat_d = beat_last ? '0 : beat_q + 1'b1;
   end
`endif

   always_ff @(posedge rd_clk) begin
      if (sclr) begin
         pipe_q <= '0;
`ifdef FIFO_STREAM_LAST_EN
         beat_q <= '0;
`endif
      end else begin
         pipe_q <= pipe_d;
`ifdef FIFO_STREAM_LAST_EN
         beat_q <= beat_d;
`endif
      end
   end

endmodule
